// File: rtl/fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO read-side controller.
package fifo_pkg;

  localparam int PKG_AW = 3;
  localparam int DEPTH  = 1 << PKG_AW;

  typedef logic [PKG_AW:0]   ptr_t;
  typedef logic [PKG_AW-1:0] addr_t;

  // Output stage: EMPTY holds nothing, HEAD presents an entry on o_data.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HEAD  = 1'b1
  } out_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_fifo_rd_ctrl_gray_decode.sv
// Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_decode #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/gray_fifo_rd_ctrl.sv
// Read-domain FIFO controller: synchronises the Gray write pointer, issues RAM reads
// and presents a one-deep valid/accept output stage with one pop per cycle.
module gray_fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int AW          = PKG_AW,
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   i_wptr_gray,
  output logic [AW:0]   o_rptr_gray,
  output logic          o_ram_ren,
  output logic [AW-1:0] o_ram_raddr,
  input  logic [W-1:0]  i_ram_rdata,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  input  logic          i_accept,
  output logic [AW:0]   o_level,
  output logic          o_empty,
  output logic          o_err,
  output out_state_e    o_state
);

  // Handshake: the head entry transfers on a cycle where o_valid && i_accept are
  // both high; o_valid never drops without a transfer except on rst, and o_data is
  // stable while o_valid is high and i_accept is low.

  typedef logic [AW:0] lptr_t;
  localparam lptr_t DEPTH_P = lptr_t'(1) << AW;

  lptr_t      sync_q [SYNC_STAGES];
  lptr_t      wptr_bin;
  lptr_t      avail;
  lptr_t      rptr_bin_q, rptr_bin_d;
  lptr_t      rptr_gray_q, rptr_gray_d;
  logic       err_q, err_d;
  logic       pop_slot;
  out_state_e state_q;

  // Plain flop chain: no logic between stages so only one Gray bit can be in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_wptr_gray;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  gray_decode #(
    .W(AW + 1)
  ) u_wptr_dec (
    .gray_i(sync_q[SYNC_STAGES-1]),
    .bin_o (wptr_bin)
  );

  always_comb begin
    avail       = wptr_bin - rptr_bin_q;
    pop_slot    = (state_q == ST_EMPTY) || i_accept;
    o_ram_ren   = (avail != '0) && pop_slot;
    rptr_bin_d  = o_ram_ren ? rptr_bin_q + lptr_t'(1) : rptr_bin_q;
    rptr_gray_d = lptr_t'(bin2gray(32'(rptr_bin_d)));
    // avail == DEPTH is a full FIFO; only beyond that has the writer overrun us.
    err_d       = err_q || (avail > DEPTH_P);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (o_ram_ren) state_q <= ST_HEAD;
        ST_HEAD:  if (i_accept && !o_ram_ren) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  assign o_valid     = (state_q == ST_HEAD);
  assign o_state     = state_q;
  assign o_data      = i_ram_rdata;
  assign o_ram_raddr = rptr_bin_q[AW-1:0];
  assign o_rptr_gray = rptr_gray_q;
  assign o_level     = avail + lptr_t'(o_valid);
  assign o_empty     = (o_level == '0);
  assign o_err       = err_q;

endmodule

// File: tb/tb_gray_fifo_rd_ctrl.sv
// Directed bench for gray_fifo_rd_ctrl (AW=3, W=32, SYNC_STAGES=2) with a synchronous-read RAM model.
module tb_gray_fifo_rd_ctrl;
  import fifo_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  wptr_gray;
  logic [3:0]  rptr_gray;
  logic        ram_ren;
  logic [2:0]  ram_raddr;
  logic [31:0] ram_rdata;
  logic        valid;
  logic [31:0] data;
  logic        accept;
  logic [3:0]  level;
  logic        empty;
  logic        err;
  out_state_e  state;

  int n_cmp = 0;
  int n_bad = 0;

  // Gray codes of binary 0..8.
  logic [3:0] g_tab [9] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

  gray_fifo_rd_ctrl #(
    .AW(3), .W(32), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wptr_gray(wptr_gray),
    .o_rptr_gray(rptr_gray),
    .o_ram_ren  (ram_ren),
    .o_ram_raddr(ram_raddr),
    .i_ram_rdata(ram_rdata),
    .o_valid    (valid),
    .o_data     (data),
    .i_accept   (accept),
    .o_level    (level),
    .o_empty    (empty),
    .o_err      (err),
    .o_state    (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  initial ram_rdata = 32'h0;
  always @(posedge clk) if (ram_ren) ram_rdata <= mem_word(int'(ram_raddr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    accept = 1'b0;
    wptr_gray = 4'b0000;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    accept = 1'b0;
    wptr_gray = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_cmp++; if (rptr_gray !== 4'd0) begin n_bad++; $display("FAIL reset_rptr: got %h want 0", rptr_gray); end
      n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL reset_ren: got %b want 0", ram_ren); end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
      n_cmp++; if (state !== ST_EMPTY) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    end
    wptr_gray = 4'b0000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    wptr_gray = 4'b0001;
    #1;
    n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL single_ren_c0: got %b want 0", ram_ren); end
    step();
    n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL single_ren_c1: got %b want 0", ram_ren); end
    step();
    n_cmp++; if (ram_ren !== 1'b1) begin n_bad++; $display("FAIL single_ren_c2: got %b want 1", ram_ren); end
    n_cmp++; if (ram_raddr !== 3'd0) begin n_bad++; $display("FAIL single_raddr: got %0d want 0", ram_raddr); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_c2: got %b want 0", valid); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level_c2: got %0d want 1", level); end
    step();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_valid_c3: got %b want 1", valid); end
    n_cmp++; if (data !== mem_word(0)) begin n_bad++; $display("FAIL single_data: got %h want %h", data, mem_word(0)); end
    n_cmp++; if (rptr_gray !== 4'b0001) begin n_bad++; $display("FAIL single_rptr: got %h want 1", rptr_gray); end
    n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL single_ren_c3: got %b want 0", ram_ren); end
    step();
    n_cmp++; if (valid !== 1'b1 || level !== 4'd1) begin n_bad++; $display("FAIL single_hold: got valid=%b level=%0d want 1/1", valid, level); end
    accept = 1'b1;
    #1;
    n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL single_ren_accept: got %b want 0", ram_ren); end
    step();
    n_cmp++; if (empty !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL single_empty: got empty=%b valid=%b want 1/0", empty, valid); end
    accept = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    wptr_gray = 4'b1100;
    accept = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (ram_ren !== 1'b1 || ram_raddr !== 3'(i)) begin n_bad++; $display("FAIL stream_issue[%0d]: got ren=%b raddr=%0d want 1/%0d", i, ram_ren, ram_raddr, i); end
      n_cmp++; if (rptr_gray !== g_tab[i]) begin n_bad++; $display("FAIL stream_rptr[%0d]: got %h want %h", i, rptr_gray, g_tab[i]); end
      if (i > 0) begin
        n_cmp++; if (valid !== 1'b1 || data !== mem_word(i - 1)) begin n_bad++; $display("FAIL stream_data[%0d]: got valid=%b data=%h want 1/%h", i, valid, data, mem_word(i - 1)); end
      end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL stream_err[%0d]: got %b want 0", i, err); end
      step();
    end
    n_cmp++; if (rptr_gray !== 4'd12) begin n_bad++; $display("FAIL stream_rptr_end: got %h want c", rptr_gray); end
    n_cmp++; if (valid !== 1'b1 || data !== mem_word(7)) begin n_bad++; $display("FAIL stream_last: got valid=%b data=%h want 1/%h", valid, data, mem_word(7)); end
    n_cmp++; if (ram_ren !== 1'b0 || level !== 4'd1) begin n_bad++; $display("FAIL stream_tail: got ren=%b level=%0d want 0/1", ram_ren, level); end
    step();
    n_cmp++; if (empty !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL stream_done: got empty=%b err=%b want 1/0", empty, err); end
    accept = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    wptr_gray = 4'b0010;
    step();
    step();
    n_cmp++; if (ram_ren !== 1'b1 || ram_raddr !== 3'd0) begin n_bad++; $display("FAIL bp_first: got ren=%b raddr=%0d want 1/0", ram_ren, ram_raddr); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (ram_ren !== 1'b0) begin n_bad++; $display("FAIL bp_ren[%0d]: got %b want 0", c, ram_ren); end
      n_cmp++; if (valid !== 1'b1 || data !== mem_word(0)) begin n_bad++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h want 1/%h", c, valid, data, mem_word(0)); end
      n_cmp++; if (level !== 4'd3 || rptr_gray !== 4'd1) begin n_bad++; $display("FAIL bp_level[%0d]: got level=%0d rptr=%h want 3/1", c, level, rptr_gray); end
    end
    accept = 1'b1;
    #1;
    n_cmp++; if (ram_ren !== 1'b1 || ram_raddr !== 3'd1) begin n_bad++; $display("FAIL bp_rel1: got ren=%b raddr=%0d want 1/1", ram_ren, ram_raddr); end
    step();
    n_cmp++; if (data !== mem_word(1) || rptr_gray !== 4'd3) begin n_bad++; $display("FAIL bp_rel2_data: got data=%h rptr=%h want %h/3", data, rptr_gray, mem_word(1)); end
    n_cmp++; if (ram_ren !== 1'b1 || ram_raddr !== 3'd2) begin n_bad++; $display("FAIL bp_rel2: got ren=%b raddr=%0d want 1/2", ram_ren, ram_raddr); end
    step();
    n_cmp++; if (data !== mem_word(2) || ram_ren !== 1'b0 || level !== 4'd1) begin n_bad++; $display("FAIL bp_rel3: got data=%h ren=%b level=%0d want %h/0/1", data, ram_ren, level, mem_word(2)); end
    step();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL bp_empty: got %b want 1", empty); end
    accept = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    accept = 1'b1;
    wptr_gray = 4'b1100;
    for (int c = 0; c < 12; c++) step();
    wptr_gray = 4'b1000;
    for (int c = 0; c < 12; c++) step();
    n_cmp++; if (rptr_gray !== 4'b1000 || empty !== 1'b1) begin n_bad++; $display("FAIL wrap_pre: got rptr=%h empty=%b want 8/1", rptr_gray, empty); end
    wptr_gray = 4'b0001;
    step();
    step();
    n_cmp++; if (ram_ren !== 1'b1 || ram_raddr !== 3'd7 || level !== 4'd2) begin n_bad++; $display("FAIL wrap_a: got ren=%b raddr=%0d level=%0d want 1/7/2", ram_ren, ram_raddr, level); end
    step();
    n_cmp++; if (ram_ren !== 1'b1 || ram_raddr !== 3'd0) begin n_bad++; $display("FAIL wrap_b: got ren=%b raddr=%0d want 1/0", ram_ren, ram_raddr); end
    n_cmp++; if (rptr_gray !== 4'd0 || data !== mem_word(7) || level !== 4'd2) begin n_bad++; $display("FAIL wrap_b_out: got rptr=%h data=%h level=%0d want 0/%h/2", rptr_gray, data, level, mem_word(7)); end
    step();
    n_cmp++; if (rptr_gray !== 4'd1 || data !== mem_word(0) || level !== 4'd1) begin n_bad++; $display("FAIL wrap_c: got rptr=%h data=%h level=%0d want 1/%h/1", rptr_gray, data, level, mem_word(0)); end
    n_cmp++; if (ram_ren !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL wrap_c_ctl: got ren=%b err=%b want 0/0", ram_ren, err); end
    step();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
    accept = 1'b0;
  endtask

  task automatic test_overflow_reset();
    do_reset();
    wptr_gray = 4'b1101;
    step();
    step();
    n_cmp++; if (err !== 1'b0 || ram_ren !== 1'b1) begin n_bad++; $display("FAIL ovf_pre: got err=%b ren=%b want 0/1", err, ram_ren); end
    step();
    n_cmp++; if (err !== 1'b1 || level !== 4'd9) begin n_bad++; $display("FAIL ovf_set: got err=%b level=%0d want 1/9", err, level); end
    accept = 1'b1;
    step();
    step();
    n_cmp++; if (err !== 1'b1 || valid !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got err=%b valid=%b want 1/1", err, valid); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (valid !== 1'b0 || rptr_gray !== 4'd0) begin n_bad++; $display("FAIL arst_a: got valid=%b rptr=%h want 0/0", valid, rptr_gray); end
    n_cmp++; if (ram_ren !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL arst_b: got ren=%b err=%b want 0/0", ram_ren, err); end
    n_cmp++; if (empty !== 1'b1 || level !== 4'd0) begin n_bad++; $display("FAIL arst_c: got empty=%b level=%0d want 1/0", empty, level); end
    accept = 1'b0;
    wptr_gray = 4'b0000;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    accept = 1'b0;
    wptr_gray = 4'b0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_overflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_fifo_rd_ctrl.md
Name: gray_fifo_rd_ctrl

Overview:
Read-side controller for a dual-clock FIFO. It sits in the read clock domain. It synchronises the write domain's Gray-coded write pointer, decodes it to binary, and computes occupancy. It then sequences reads from a synchronous-read RAM and returns its own Gray-coded read pointer to the write side. Output is a valid/accept stream that sustains one pop per cycle.

Parameters:
AW, 3, log2 of FIFO depth; pointers are AW+1 bits wide.
W, 32, data width.
SYNC_STAGES, 2, flops in the write-pointer synchroniser (minimum 2).

Ports:
clk  in  1  read-domain clock
rst  in  1  asynchronous reset, active-high
i_wptr_gray  in  AW+1  write pointer, Gray-coded, from the write domain (asynchronous to clk)
o_rptr_gray  out  AW+1  registered read pointer, Gray-coded, sent to the write domain
o_ram_ren  out  1  RAM read enable
o_ram_raddr  out  AW  RAM read address
i_ram_rdata  in  W  RAM read data; valid the cycle after o_ram_ren; held by the RAM while ren is low
o_valid  out  1  head entry is present on o_data
o_data  out  W  head entry; equals i_ram_rdata
i_accept  in  1  consumer takes the head when o_valid is high
o_level  out  AW+1  entries not yet popped
o_empty  out  1  o_level == 0
o_err  out  1  sticky occupancy-overflow flag

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high on rst. On reset:
  - all synchroniser flops = 0
  - rptr_bin = 0, o_rptr_gray = 0
  - o_valid = 0, o_err = 0, o_ram_ren = 0
  - o_level = 0, o_empty = 1
- Synchroniser: i_wptr_gray passes through SYNC_STAGES flops with no logic between them.
  - wptr_bin = Gray-to-binary decode of the last flop stage.
- Pending count (unsigned): avail = (wptr_bin - rptr_bin) mod 2^(AW+1).
- Read issue is combinational: o_ram_ren = (avail != 0) && (!o_valid || i_accept).
  - o_ram_raddr = rptr_bin[AW-1:0].
- Pointer update: on a cycle with o_ram_ren=1:
  - rptr_bin <= rptr_bin + 1, wrapping 2^(AW+1)-1 -> 0
  - o_rptr_gray <= next rptr_bin ^ (next rptr_bin >> 1)
  - o_rptr_gray changes exactly one bit per increment, including at wrap.
- Output valid register:
  - o_valid <= o_ram_ren on any cycle with (!o_valid || i_accept); otherwise it holds.
  - Read latency: ren at cycle t gives o_valid=1 at t+1.
  - Throughput is 1 entry/cycle while avail != 0 and i_accept=1.
- Simultaneous pop and refill: o_valid && i_accept && avail != 0 issues a new read in the same cycle. o_valid stays 1 and o_data changes at the next edge.
- Backpressure: o_valid && !i_accept gives no read. o_valid, o_data and the pointer are all held.
- Accept while invalid: i_accept with o_valid=0 is ignored.
- Level outputs: o_level = avail + o_valid, computed combinationally. o_empty = (o_level == 0).
- Overflow:
  - avail > 2^AW sets o_err; it stays set until rst.
  - Reads continue as normal; the controller takes no corrective action.
- Wrap-around: pointer full-width arithmetic is mod 2^(AW+1). avail == 2^AW is a legal full FIFO, not an error.
- Reset mid-stream: all state clears immediately.
  - An in-flight read is discarded; o_valid drops with no handshake.
  - The write side must be reset coherently (system requirement).
- State summary: the two-state output stage is EMPTY (o_valid=0) and HEAD (o_valid=1).
  - EMPTY -> HEAD on ren.
  - HEAD -> EMPTY on accept with no ren.
  - HEAD stays HEAD on accept with ren, or on no accept.

Decomposition:
- Shared package fifo_pkg:
  - ptr_t (logic [AW:0]) and addr_t typedefs
  - bin-to-Gray function
  - localparam DEPTH = 1<<AW
- One sub-module: a gray_decode instance, W=AW+1, on the synchronised write pointer.
- The synchroniser is inline flops, not a separate module.

Test Plan:
1. Reset: assert rst with i_wptr_gray=0b0101 -> o_valid=0, o_rptr_gray=0, o_ram_ren=0, o_empty=1, o_err=0; these hold while rst=1.
2. Single entry (AW=3, SYNC_STAGES=2): i_wptr_gray 0->0b0001 at cycle 0 -> o_ram_ren=1, raddr=0 at cycle 2; o_valid=1 at cycle 3; o_rptr_gray=0b0001; o_level=1 until i_accept, then o_empty=1.
3. Streaming: wptr bin 8 (gray 0b1100) with i_accept=1 -> 8 back-to-back rens, raddr 0..7; o_rptr_gray sequence 1,3,2,6,7,5,4,12; full FIFO gives no o_err; o_empty=1 after the last accept.
4. Backpressure: wptr bin 3, i_accept=0 -> exactly one ren; o_valid and o_data held; o_level=3; o_rptr_gray=1; then i_accept=1 for 3 cycles -> raddr 1,2 issued, o_empty=1.
5. Wrap: preload rptr to bin 15 via traffic, wptr to bin 17 -> raddr 7 then 0; o_rptr_gray 8->0->1; o_level correct across the wrap.
6. Overflow and mid-stream reset: wptr bin 9 with rptr 0 -> o_err=1 and sticky; async rst mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
